// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one instruction-memory request at a time,
// captures the response and handles stall, redirect, trap and halt.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_HOLD   = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        halt_pend_q, halt_pend_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  logic        flow_change;
  logic [31:0] new_pc;
  logic        accept;
  logic        consumed;
  logic        halt_now;

  assign flow_change = trap | redirect_valid;
  assign new_pc      = trap ? TRAP_VECTOR : (redirect_target & 32'hFFFF_FFFC);
  // A stale response left over from a reset blocks new requests until it drains.
  assign accept      = (state_q == S_REQ) && !flush_q && imem_ready;
  assign consumed    = instr_valid_q && !stall;
  assign halt_now    = halt_pend_q | halt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VECTOR;
      flush_q       <= (state_q == S_WAIT) && !imem_rvalid;
      halt_pend_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      halt_pend_q   <= halt_pend_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_d       = flush_q;
    halt_pend_d   = halt_pend_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (consumed) instr_valid_d = 1'b0;
        if (flush_q && imem_rvalid) flush_d = 1'b0;
        if (flow_change) begin
          pc_d          = new_pc;
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end else if (halt) begin
          instr_valid_d = 1'b0;
          state_d       = S_HALTED;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (consumed) instr_valid_d = 1'b0;
        if (flush_q && imem_rvalid) flush_d = 1'b0;
        if (flow_change) begin
          pc_d          = new_pc;
          instr_valid_d = 1'b0;
          // Accepted in the same cycle: its response belongs to the old path.
          if (accept) begin
            flush_d = 1'b1;
            state_d = S_WAIT;
          end
        end else if (halt) begin
          instr_valid_d = 1'b0;
          if (accept) begin
            halt_pend_d = 1'b1;
            state_d     = S_WAIT;
          end else begin
            state_d = S_HALTED;
          end
        end else if (accept) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (consumed) instr_valid_d = 1'b0;
        if (flow_change) begin
          pc_d          = new_pc;
          instr_valid_d = 1'b0;
          if (imem_rvalid) begin
            flush_d = 1'b0;
            state_d = halt_pend_q ? S_HALTED : S_REQ;
          end else begin
            flush_d = 1'b1;
          end
        end else begin
          if (halt) halt_pend_d = 1'b1;
          if (imem_rvalid) begin
            if (flush_q) begin
              flush_d = 1'b0;
              state_d = halt_now ? S_HALTED : S_REQ;
            end else begin
              instr_d       = imem_rdata;
              instr_pc_d    = pc_q;
              instr_valid_d = 1'b1;
              pc_d          = pc_q + 32'd4;
              // A pending halt parks in HOLD so the instruction is seen before stopping.
              state_d       = (stall || halt_now) ? S_HOLD : S_REQ;
            end
          end
        end
      end
      S_HOLD: begin
        if (flow_change) begin
          pc_d          = new_pc;
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end else begin
          if (halt) halt_pend_d = 1'b1;
          if (!stall) begin
            instr_valid_d = 1'b0;
            state_d       = halt_now ? S_HALTED : S_REQ;
          end
        end
      end
      S_HALTED: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    imem_req    = (state_q == S_REQ) && !flush_q;
    imem_addr   = pc_q;
    halted      = (state_q == S_HALTED);
    instr_valid = instr_valid_q;
    instr       = instr_q;
    instr_pc    = instr_pc_q;
  end

endmodule
